// File: rtl/gr_nibble_reader_if.sv
// -----------------------------------------------------------------------------
// gr_nibble_reader_if
//
// Purpose : Groups the read-select, register and data-bus handshake signals of
//           gr_nibble_reader into one bundle.
//
// Signals : rd_req, rd_lsb, rd_msb  read request and nibble selects (control unit)
//           gr_2_bus [7:0]          current general register value
//           bus_ready               bus consumer accepts the current beat
//           bus_out  [7:0]          data beat
//           bus_valid               bus_out is valid
//           rd_busy                 read in progress
//           rd_done                 one-cycle completion strobe
//           bus_parity              XOR of bus_out (only with GR_RD_PARITY_EN)
//
// Modports: master - control unit / bus consumer side
//           slave  - gr_nibble_reader side
//
// Build option: define GR_RD_PARITY_EN to add bus_parity.
// -----------------------------------------------------------------------------
interface gr_nibble_reader_if;
    logic       rd_req;
    logic       rd_lsb;
    logic       rd_msb;
    logic [7:0] gr_2_bus;
    logic       bus_ready;
    logic [7:0] bus_out;
    logic       bus_valid;
    logic       rd_busy;
    logic       rd_done;
`ifdef GR_RD_PARITY_EN
    logic       bus_parity;

    modport master (
        output rd_req, rd_lsb, rd_msb, gr_2_bus, bus_ready,
        input  bus_out, bus_valid, rd_busy, rd_done, bus_parity
    );

    modport slave (
        input  rd_req, rd_lsb, rd_msb, gr_2_bus, bus_ready,
        output bus_out, bus_valid, rd_busy, rd_done, bus_parity
    );
`else
    modport master (
        output rd_req, rd_lsb, rd_msb, gr_2_bus, bus_ready,
        input  bus_out, bus_valid, rd_busy, rd_done
    );

    modport slave (
        input  rd_req, rd_lsb, rd_msb, gr_2_bus, bus_ready,
        output bus_out, bus_valid, rd_busy, rd_done
    );
`endif
endinterface

// File: rtl/gr_nibble_reader.sv
// -----------------------------------------------------------------------------
// gr_nibble_reader
//
// Purpose : Read-side counterpart of the nibble-loaded general register. On a
//           read request it snapshots the register and returns the low nibble,
//           the high nibble or the full byte to the 8-bit data bus using a
//           valid/ready handshake, then pulses rd_done for one cycle.
//
// Ports   : clk   - system clock, rising edge
//           rst   - asynchronous, active-low reset
//           bus   - gr_nibble_reader_if.slave (selects, register value,
//                   bus_out/bus_valid/bus_ready handshake, rd_busy, rd_done)
//
// Parameters:
//           SPLIT_FULL - 1: full-byte read is sent as two nibble beats, LSB first
//                        0: full-byte read is one 8-bit beat
//           ZERO_FILL  - 1: bus_out[7:4] is 0 on nibble beats
//                        0: bus_out[7:4] carries the snapshot's other nibble
//
// Build option: define GR_RD_PARITY_EN to add bus.bus_parity (XOR of bus_out),
//           registered alongside bus_out.
// -----------------------------------------------------------------------------
module gr_nibble_reader #(
    parameter bit SPLIT_FULL = 1'b0,
    parameter bit ZERO_FILL  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    gr_nibble_reader_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q;
    logic [7:0] snap_q;
    logic [1:0] mode_q;      // {msb, lsb} captured with the request
    logic       beat_cnt_q;  // 0 while the first beat is on the bus, 1 on the second
    logic [7:0] bus_out_q;
    logic       bus_valid_q;
    logic       rd_busy_q;
    logic       rd_done_q;
`ifdef GR_RD_PARITY_EN
    logic       bus_parity_q;
`endif

    // Places a nibble in bus_out[3:0] and fills the upper half per ZERO_FILL.
    function automatic logic [7:0] fill_nibble(input logic [3:0] nib,
                                               input logic [3:0] other);
        if (ZERO_FILL) begin
            return {4'h0, nib};
        end
        return {other, nib};
    endfunction

    // First beat of a read, formed straight from the register so that the
    // beat can be registered in the same edge that takes the snapshot.
    function automatic logic [7:0] beat0_word(input logic [7:0] val,
                                              input logic [1:0] mode);
        case (mode)
            2'b01:   return fill_nibble(val[3:0], val[7:4]);
            2'b10:   return fill_nibble(val[7:4], val[3:0]);
            default: begin
                if (SPLIT_FULL) begin
                    return fill_nibble(val[3:0], val[7:4]);
                end
                return val;
            end
        endcase
    endfunction

    // Second beat only exists for a split full-byte read: the high nibble.
    function automatic logic [7:0] beat1_word(input logic [7:0] val);
        return fill_nibble(val[7:4], val[3:0]);
    endfunction

    logic [1:0] req_mode_d;
    logic       req_ok_d;
    logic [7:0] beat0_d;
    logic [7:0] beat1_d;
    logic       xfer_d;
    logic       last_beat_d;

    assign req_mode_d  = {bus.rd_msb, bus.rd_lsb};
    assign req_ok_d    = bus.rd_req & (bus.rd_lsb | bus.rd_msb);
    assign beat0_d     = beat0_word(bus.gr_2_bus, req_mode_d);
    assign beat1_d     = beat1_word(snap_q);
    assign xfer_d      = bus_valid_q & bus.bus_ready;
    // Only a split full-byte read has a second beat.
    assign last_beat_d = (mode_q != 2'b11) || !SPLIT_FULL || beat_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            snap_q       <= 8'h00;
            mode_q       <= 2'b00;
            beat_cnt_q   <= 1'b0;
            bus_out_q    <= 8'h00;
            bus_valid_q  <= 1'b0;
            rd_busy_q    <= 1'b0;
            rd_done_q    <= 1'b0;
`ifdef GR_RD_PARITY_EN
            bus_parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    rd_done_q <= 1'b0;
                    if (req_ok_d) begin
                        snap_q       <= bus.gr_2_bus;
                        mode_q       <= req_mode_d;
                        beat_cnt_q   <= 1'b0;
                        bus_out_q    <= beat0_d;
                        bus_valid_q  <= 1'b1;
                        rd_busy_q    <= 1'b1;
`ifdef GR_RD_PARITY_EN
                        bus_parity_q <= ^beat0_d;
`endif
                        state_q      <= BEAT0;
                    end
                end

                BEAT0, BEAT1: begin
                    // Beat is held until the consumer takes it; requests are ignored.
                    if (xfer_d) begin
                        if (last_beat_d) begin
                            bus_out_q    <= 8'h00;
                            bus_valid_q  <= 1'b0;
                            rd_done_q    <= 1'b1;
`ifdef GR_RD_PARITY_EN
                            bus_parity_q <= 1'b0;
`endif
                            state_q      <= DONE;
                        end else begin
                            bus_out_q    <= beat1_d;
                            beat_cnt_q   <= 1'b1;
`ifdef GR_RD_PARITY_EN
                            bus_parity_q <= ^beat1_d;
`endif
                            state_q      <= BEAT1;
                        end
                    end
                end

                DONE: begin
                    rd_done_q  <= 1'b0;
                    rd_busy_q  <= 1'b0;
                    beat_cnt_q <= 1'b0;
                    state_q    <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.bus_out    = bus_out_q;
    assign bus.bus_valid  = bus_valid_q;
    assign bus.rd_busy    = rd_busy_q;
    assign bus.rd_done    = rd_done_q;
`ifdef GR_RD_PARITY_EN
    assign bus.bus_parity = bus_parity_q;
`endif

endmodule

// File: tb/tb_gr_nibble_reader.sv
// -----------------------------------------------------------------------------
// tb_gr_nibble_reader
//
// Three instances share one stimulus stream:
//   A: SPLIT_FULL=0, ZERO_FILL=1   B: SPLIT_FULL=1, ZERO_FILL=0
//   C: SPLIT_FULL=1, ZERO_FILL=1
// A reference model keeps, per instance, the list of beats still owed to the
// bus and a pending-completion flag, derived from the read rules.
// -----------------------------------------------------------------------------
module tb_gr_nibble_reader;

    logic       clk;
    logic       rst;
    logic       req;
    logic       lsb;
    logic       msb;
    logic [7:0] gr;
    logic       rdy;

    gr_nibble_reader_if ifa ();
    gr_nibble_reader_if ifb ();
    gr_nibble_reader_if ifc ();

    assign ifa.rd_req = req;  assign ifb.rd_req = req;  assign ifc.rd_req = req;
    assign ifa.rd_lsb = lsb;  assign ifb.rd_lsb = lsb;  assign ifc.rd_lsb = lsb;
    assign ifa.rd_msb = msb;  assign ifb.rd_msb = msb;  assign ifc.rd_msb = msb;
    assign ifa.gr_2_bus = gr; assign ifb.gr_2_bus = gr; assign ifc.gr_2_bus = gr;
    assign ifa.bus_ready = rdy; assign ifb.bus_ready = rdy; assign ifc.bus_ready = rdy;

    logic pa, pb, pc;
`ifdef GR_RD_PARITY_EN
    assign pa = ifa.bus_parity;
    assign pb = ifb.bus_parity;
    assign pc = ifc.bus_parity;
`else
    assign pa = 1'b0;
    assign pb = 1'b0;
    assign pc = 1'b0;
`endif

    gr_nibble_reader #(.SPLIT_FULL(1'b0), .ZERO_FILL(1'b1)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    gr_nibble_reader #(.SPLIT_FULL(1'b1), .ZERO_FILL(1'b0)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));
    gr_nibble_reader #(.SPLIT_FULL(1'b1), .ZERO_FILL(1'b1)) u_dut_c (.clk(clk), .rst(rst), .bus(ifc));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    logic [7:0] pend [3][2];
    int         pend_n [3];
    bit         done_p [3];

    function automatic bit sf(input int k);
        return (k != 0);
    endfunction

    function automatic bit zf(input int k);
        return (k != 1);
    endfunction

    function automatic logic [7:0] nibw(input logic [3:0] n, input logic [3:0] o, input bit z);
        return z ? {4'h0, n} : {o, n};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            pend_n[k] = 0;
            done_p[k] = 1'b0;
            pend[k][0] = 8'h00;
            pend[k][1] = 8'h00;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (done_p[k]) begin
                done_p[k] = 1'b0;
            end else if (pend_n[k] > 0) begin
                if (rdy) begin
                    pend[k][0] = pend[k][1];
                    pend_n[k]  = pend_n[k] - 1;
                    if (pend_n[k] == 0) done_p[k] = 1'b1;
                end
            end else if (req && (lsb || msb)) begin
                if (lsb && msb && !sf(k)) begin
                    pend[k][0] = gr;
                    pend_n[k]  = 1;
                end else if (lsb && msb) begin
                    pend[k][0] = nibw(gr[3:0], gr[7:4], zf(k));
                    pend[k][1] = nibw(gr[7:4], gr[3:0], zf(k));
                    pend_n[k]  = 2;
                end else if (lsb) begin
                    pend[k][0] = nibw(gr[3:0], gr[7:4], zf(k));
                    pend_n[k]  = 1;
                end else begin
                    pend[k][0] = nibw(gr[7:4], gr[3:0], zf(k));
                    pend_n[k]  = 1;
                end
            end
        end
    endtask

    // ---------------- comparison helpers ----------------
    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int k, input logic [7:0] o, input logic v,
                             input logic b, input logic d, input logic p);
        logic [7:0] eo;
        logic       ev;
        ev = (pend_n[k] > 0);
        eo = ev ? pend[k][0] : 8'h00;
        cmp($sformatf("dut%0d bus_out", k),   o, eo);
        cmp($sformatf("dut%0d bus_valid", k), {7'b0, v}, {7'b0, ev});
        cmp($sformatf("dut%0d rd_busy", k),   {7'b0, b}, {7'b0, ev | done_p[k]});
        cmp($sformatf("dut%0d rd_done", k),   {7'b0, d}, {7'b0, done_p[k]});
`ifdef GR_RD_PARITY_EN
        cmp($sformatf("dut%0d bus_parity", k), {7'b0, p}, {7'b0, ^eo});
`else
        if (p !== 1'b0) cmp($sformatf("dut%0d parity tie", k), {7'b0, p}, 8'h00);
`endif
    endtask

    task automatic check_all();
        check_dut(0, ifa.bus_out, ifa.bus_valid, ifa.rd_busy, ifa.rd_done, pa);
        check_dut(1, ifb.bus_out, ifb.bus_valid, ifb.rd_busy, ifb.rd_done, pb);
        check_dut(2, ifc.bus_out, ifc.bus_valid, ifc.rd_busy, ifc.rd_done, pc);
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic r, input logic l, input logic m,
                         input logic [7:0] g, input logic y);
        req = r; lsb = l; msb = m; gr = g; rdy = y;
    endtask

    task automatic idle_steps(input int n);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset pulse taken between clock edges.
    task automatic async_reset_pulse();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- directed table for instance A ----------------
    typedef struct {
        logic       req;
        logic       lsb;
        logic       msb;
        logic [7:0] gr;
        logic       rdy;
        logic [7:0] eout;
        logic       ev;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'h96, 1'b1, 8'h96, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h77, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

        model_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'($urandom), 1'b1);

        // Reset taken before any clock edge: outputs must clear asynchronously.
        #2;
        rst = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        step();

        // Directed vectors, compared against fixed expectations for A.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].req, tbl[i].lsb, tbl[i].msb, tbl[i].gr, tbl[i].rdy);
            step();
            cmp($sformatf("tbl%0d A bus_out", i),   ifa.bus_out, tbl[i].eout);
            cmp($sformatf("tbl%0d A bus_valid", i), {7'b0, ifa.bus_valid}, {7'b0, tbl[i].ev});
            cmp($sformatf("tbl%0d A rd_busy", i),   {7'b0, ifa.rd_busy},   {7'b0, tbl[i].eb});
            cmp($sformatf("tbl%0d A rd_done", i),   {7'b0, ifa.rd_done},   {7'b0, tbl[i].ed});
        end

        // Split full-byte read on C: 06 then 09 then completion.
        idle_steps(4);
        drive(1'b1, 1'b1, 1'b1, 8'h96, 1'b1);
        step();
        cmp("split C beat0", ifc.bus_out, 8'h06);
        cmp("split C valid0", {7'b0, ifc.bus_valid}, 8'h01);
`ifdef GR_RD_PARITY_EN
        cmp("split C parity0", {7'b0, ifc.bus_parity}, 8'h00);
`endif
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step();
        cmp("split C beat1", ifc.bus_out, 8'h09);
        cmp("split B beat1", ifb.bus_out, 8'h69);
`ifdef GR_RD_PARITY_EN
        cmp("split C parity1", {7'b0, ifc.bus_parity}, 8'h00);
`endif
        step();
        cmp("split C done", {7'b0, ifc.rd_done}, 8'h01);
        cmp("split C valid end", {7'b0, ifc.bus_valid}, 8'h00);

        // Reset while C is on its second beat: abort, no completion, then recover.
        idle_steps(4);
        drive(1'b1, 1'b1, 1'b1, 8'h96, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step();
        cmp("pre-abort C beat1", ifc.bus_out, 8'h09);
        rdy = 1'b0;
        async_reset_pulse();
        cmp("abort C bus_out", ifc.bus_out, 8'h00);
        cmp("abort C busy", {7'b0, ifc.rd_busy}, 8'h00);
        idle_steps(2);
        cmp("abort C no done", {7'b0, ifc.rd_done}, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'h5A, 1'b1);
        step();
        cmp("recover C beat", ifc.bus_out, 8'h0A);
        cmp("recover B beat", ifb.bus_out, 8'h5A);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step();
        cmp("recover C done", {7'b0, ifc.rd_done}, 8'h01);

        // Randomized traffic against the model, with occasional async resets.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
                  8'($urandom), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 149) == 0) begin
                async_reset_pulse();
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gr_nibble_reader.md
Name: gr_nibble_reader

Overview:
- Read-side counterpart of the nibble-loaded general register: returns the register contents to the 8-bit data bus in LSB, MSB or full-byte form.
- Snapshots the register value on a read request and presents it on the bus using a valid/ready handshake.
- Pulses a completion strobe to the control unit when the read finishes.
- Sits between the general register output and the shared data bus; it is driven by the control unit's read-select lines.

Parameters:
- SPLIT_FULL, 0, 1 = a full-byte read (lsb+msb) is sent as two nibble beats, LSB first; 0 = one 8-bit beat.
- ZERO_FILL, 1, 1 = bus_out[7:4] is driven 0 on nibble beats; 0 = bus_out[7:4] holds the snapshot's other nibble.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- rd_req  input  1  read request, sampled in IDLE only
- rd_lsb  input  1  select low nibble, sampled with rd_req
- rd_msb  input  1  select high nibble, sampled with rd_req
- gr_2_bus  input  8  current general register value
- bus_ready  input  1  bus consumer accepts the current beat
- bus_out  output  8  data beat
- bus_valid  output  1  bus_out is valid
- rd_busy  output  1  read in progress (any state but IDLE)
- rd_done  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; bus_out=0, bus_valid=0, rd_busy=0, rd_done=0; snapshot=0; beat counter=0.
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE:
  - rd_req=1 with (rd_lsb|rd_msb)=1: capture snap<=gr_2_bus and mode<={rd_msb,rd_lsb}; go to BEAT0.
  - rd_req=1 with neither select: ignored; stay IDLE; no rd_done.
  - Latency: request sampled at edge N gives bus_valid=1 after edge N.
- Beat 0 contents:
  - mode 01: bus_out[3:0]=snap[3:0].
  - mode 10: bus_out[3:0]=snap[7:4].
  - mode 11, SPLIT_FULL=0: bus_out=snap.
  - mode 11, SPLIT_FULL=1: bus_out[3:0]=snap[3:0].
  - Upper bits on nibble beats: 0 when ZERO_FILL=1; otherwise the opposite nibble.
- Handshake:
  - A beat transfers on any edge with bus_valid=1 and bus_ready=1.
  - bus_out and bus_valid are held stable until the transfer; bus_ready may be low indefinitely.
- BEAT0 transfer:
  - To BEAT1 when mode=11 and SPLIT_FULL=1; otherwise to DONE.
- BEAT1:
  - bus_out[3:0]=snap[7:4], with the same upper-bit fill rule.
  - Transfer goes to DONE.
- DONE:
  - bus_valid=0, rd_done=1 for exactly one cycle; then IDLE.
  - rd_req during DONE is ignored.
  - Back-to-back reads: the next request is accepted at the first edge in IDLE.
- rd_busy=1 in BEAT0, BEAT1 and DONE.
- Any rd_req while rd_busy=1 is ignored; it is neither queued nor errored.
- The snapshot isolates the transfer: changes on gr_2_bus after capture do not affect beats in flight.
- Reset asserted mid-transfer aborts immediately to reset values. No rd_done is produced for the aborted read.
- bus_out is 0 whenever bus_valid=0.
- The block does not tristate; bus arbitration is external.

Optional Feature:
- Macro: GR_RD_PARITY_EN.
- Defined:
  - Adds output port bus_parity (1 bit) = XOR of bus_out[7:0].
  - Valid whenever bus_valid=1; 0 otherwise and at reset.
  - Registered together with bus_out, so there is no extra latency.
- Undefined: the port is absent and behaviour is otherwise identical.

Test Plan:
- Reset check:
  - Stimulus: assert rst=0 with rd_req=1 and random gr_2_bus.
  - Response: all outputs 0 asynchronously, with no clock edge needed.
  - Stimulus: release rst.
  - Response: IDLE, bus_valid=0.
- LSB read:
  - Stimulus: gr_2_bus=8'hA5, rd_req+rd_lsb for one cycle, bus_ready=1.
  - Response: next cycle bus_out=8'h05, bus_valid=1; following cycle rd_done=1; then IDLE.
- MSB read with stall and snapshot:
  - Stimulus: gr_2_bus=8'h3C, rd_msb read, bus_ready=0 for 3 cycles; gr_2_bus changed to 8'hFF during the stall.
  - Response: bus_out stays 8'h03 with bus_valid=1 for all 3 cycles; transfer occurs on bus_ready=1.
- Full-byte read, SPLIT_FULL=0:
  - Stimulus: gr_2_bus=8'h96, rd_lsb+rd_msb.
  - Response: single beat 8'h96, then rd_done.
- Full-byte read, SPLIT_FULL=1, ZERO_FILL=1:
  - Stimulus: gr_2_bus=8'h96, rd_lsb+rd_msb.
  - Response: beats 8'h06 then 8'h09, then rd_done.
  - With GR_RD_PARITY_EN defined: bus_parity=0 on both beats.
- Ignored requests and mid-read reset:
  - Stimulus: rd_req with no select.
  - Response: no activity.
  - Stimulus: rd_req while busy.
  - Response: ignored.
  - Stimulus: rst=0 during BEAT1.
  - Response: immediate abort, no rd_done; the next request after reset works normally.
